// File: rtl/hazard_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forwarding selects,
// FSM states and the PC register index, plus the forwarding-hit helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      HZ_RUN       = 2'b00,
      HZ_BR_REFILL = 2'b01,
      HZ_MEM_WAIT  = 2'b10
   } hz_state_t;

   localparam logic [3:0] REG_PC = 4'hF;

   // The PC is produced by the fetch path, never by a later stage's result.
   function automatic logic fwd_hit(input logic       regwrite,
                                    input logic [3:0] wa,
                                    input logic [3:0] ra);
      return regwrite && (wa == ra) && (ra != REG_PC);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Combinational forwarding compare for one E-stage source operand.
// M-stage result takes priority over W-stage result.
module fwd_unit
   import hazard_pkg::*;
(
   input  logic       regwrite_m_i,
   input  logic       regwrite_w_i,
   input  logic [3:0] wa3m_i,
   input  logic [3:0] wa3w_i,
   input  logic [3:0] ra_e_i,
   output fwd_sel_t   sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (fwd_hit(regwrite_m_i, wa3m_i, ra_e_i)) begin
         sel_o = FWD_M;
      end else if (fwd_hit(regwrite_w_i, wa3w_i, ra_e_i)) begin
         sel_o = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stalls, branch refill and memory-wait FSM.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REFILL_CYCLES = 1,
   parameter int MAX_WAIT      = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ra1d,
   input  logic [3:0] ra2d,
   input  logic [3:0] ra1e,
   input  logic [3:0] ra2e,
   input  logic [3:0] wa3e,
   input  logic [3:0] wa3m,
   input  logic [3:0] wa3w,
   input  logic       regwrite_m,
   input  logic       regwrite_w,
   input  logic       memtoreg_e,
   input  logic       branch_taken_e,
   input  logic       mem_req_m,
   input  logic       mem_ready_m,
   output logic [1:0] forward_ae,
   output logic [1:0] forward_be,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       stall_m,
   output logic       flush_d,
   output logic       flush_e,
   output logic       flush_w,
   output logic       mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_ldstall,
   output logic [31:0] perf_flush,
   output logic [31:0] perf_memwait
`endif
);

   localparam int              WCNT_W      = $clog2(MAX_WAIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(MAX_WAIT);
   localparam logic [2:0]      REFILL_INIT = 3'(REFILL_CYCLES);

   hz_state_t          state_q, state_d;
   logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [2:0]         refill_cnt_q, refill_cnt_d;
   fwd_sel_t           fwd_hold_q [2];

   logic [3:0]  ra_e [2];
   fwd_sel_t    fwd_live [2];
   fwd_sel_t    fwd_out [2];
   logic        hold_fwd;
   logic        ldstall, mem_wait_req, ldstall_apply;
   logic        stall_fd_c, stall_em_c, flush_d_c, flush_e_c, flush_w_c, mem_err_c;

   assign ra_e[0] = ra1e;
   assign ra_e[1] = ra2e;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_unit u_fwd (
         .regwrite_m_i (regwrite_m),
         .regwrite_w_i (regwrite_w),
         .wa3m_i       (wa3m),
         .wa3w_i       (wa3w),
         .ra_e_i       (ra_e[gi]),
         .sel_o        (fwd_live[gi])
      );
      assign fwd_out[gi] = hold_fwd ? fwd_hold_q[gi] : fwd_live[gi];
   end

   assign ldstall      = memtoreg_e && (wa3e != REG_PC) && ((wa3e == ra1d) || (wa3e == ra2d));
   assign mem_wait_req = mem_req_m && !mem_ready_m;

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      refill_cnt_d  = refill_cnt_q;
      hold_fwd      = 1'b0;
      ldstall_apply = 1'b0;
      stall_fd_c    = 1'b0;
      stall_em_c    = 1'b0;
      flush_d_c     = 1'b0;
      flush_e_c     = 1'b0;
      flush_w_c     = 1'b0;
      mem_err_c     = 1'b0;
      case (state_q)
         HZ_RUN, HZ_BR_REFILL: begin
            if (mem_wait_req) begin
               // Entering a wait drops any remaining refill: F/D are frozen anyway.
               state_d      = HZ_MEM_WAIT;
               wait_cnt_d   = WCNT_W'(1);
               refill_cnt_d = 3'd0;
               stall_fd_c   = 1'b1;
               stall_em_c   = 1'b1;
               flush_w_c    = 1'b1;
            end else if (state_q == HZ_BR_REFILL) begin
               flush_d_c = 1'b1;
               if (refill_cnt_q <= 3'd1) begin
                  state_d      = HZ_RUN;
                  refill_cnt_d = 3'd0;
               end else begin
                  refill_cnt_d = refill_cnt_q - 3'd1;
               end
            end else if (branch_taken_e) begin
               state_d      = HZ_BR_REFILL;
               refill_cnt_d = REFILL_INIT;
               flush_d_c    = 1'b1;
               flush_e_c    = 1'b1;
            end else if (ldstall) begin
               ldstall_apply = 1'b1;
               stall_fd_c    = 1'b1;
               flush_e_c     = 1'b1;
            end
         end
         HZ_MEM_WAIT: begin
            hold_fwd = 1'b1;
            if (mem_ready_m) begin
               state_d    = HZ_RUN;
               wait_cnt_d = '0;
            end else begin
               stall_fd_c = 1'b1;
               stall_em_c = 1'b1;
               flush_w_c  = 1'b1;
               if (wait_cnt_q >= WAIT_MAX) begin
                  mem_err_c  = 1'b1;
                  state_d    = HZ_RUN;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = HZ_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= HZ_RUN;
         wait_cnt_q    <= '0;
         refill_cnt_q  <= 3'd0;
         fwd_hold_q[0] <= FWD_RF;
         fwd_hold_q[1] <= FWD_RF;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         refill_cnt_q <= refill_cnt_d;
         if (!hold_fwd) begin
            fwd_hold_q[0] <= fwd_live[0];
            fwd_hold_q[1] <= fwd_live[1];
         end
      end
   end

   // Outputs are forced quiet while reset is held, whatever the inputs show.
   assign forward_ae = reset ? fwd_out[0] : FWD_RF;
   assign forward_be = reset ? fwd_out[1] : FWD_RF;
   assign stall_f    = reset & stall_fd_c;
   assign stall_d    = reset & stall_fd_c;
   assign stall_e    = reset & stall_em_c;
   assign stall_m    = reset & stall_em_c;
   assign flush_d    = reset & flush_d_c;
   assign flush_e    = reset & flush_e_c;
   assign flush_w    = reset & flush_w_c;
   assign mem_err    = reset & mem_err_c;

`ifdef HAZARD_PERF_EN
   logic perf_cond [3];
   assign perf_cond[0] = ldstall_apply;
   assign perf_cond[1] = flush_d_c;
   assign perf_cond[2] = stall_em_c;

   for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      logic [31:0] cnt_q;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
         end else if (perf_cond[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end

   assign perf_ldstall = g_perf[0].cnt_q;
   assign perf_flush   = g_perf[1].cnt_q;
   assign perf_memwait = g_perf[2].cnt_q;
`endif

endmodule
